// File: rtl/spi_xfer_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI core.
// One transaction at a time: grant, start pulse, wait for completion or timeout, then inter-frame holdoff.
module spi_xfer_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            req_rx,
    input  logic [1:0]            req_tx,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [1:0]            req0_freq,
    input  logic [1:0]            req1_freq,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic [1:0]            err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  spi_rx_start,
    output logic                  spi_tx_start,
    output logic [DATA_WIDTH-1:0] spi_miso_data,
    output logic [1:0]            spi_freq,
    output logic                  spi_cs_bar,
    input  logic                  spi_rx_valid,
    input  logic                  spi_tx_done,
    input  logic [DATA_WIDTH-1:0] spi_mosi_data
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LAUNCH  = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  last_q, last_d;
    logic                  idx_q, idx_d;
    logic                  rx_q, rx_d;
    logic                  tx_q, tx_d;
    logic                  null_q, null_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  rx_start_q, rx_start_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0] miso_q, miso_d;
    logic [1:0]            freq_q, freq_d;
    logic                  cs_bar_q, cs_bar_d;

    logic                  win_s;
    logic                  sel_rx_s;
    logic                  sel_tx_s;
    logic                  complete_s;

    // Next-state and next-output computation for the transaction FSM
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        idx_d      = idx_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        null_d     = null_q;
        tmo_cnt_d  = tmo_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        gnt_d      = gnt_q;
        done_d     = 2'b00;
        err_d      = 2'b00;
        rdata_d    = rdata_q;
        rx_start_d = 1'b0;
        tx_start_d = 1'b0;
        miso_d     = miso_q;
        freq_d     = freq_q;
        cs_bar_d   = 1'b0;

        // On a tie the requester that was not served last wins
        win_s      = (req == 2'b11) ? ~last_q : req[1];
        sel_rx_s   = win_s ? req_rx[1] : req_rx[0];
        sel_tx_s   = win_s ? req_tx[1] : req_tx[0];
        complete_s = spi_rx_valid | spi_tx_done;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    idx_d  = win_s;
                    gnt_d  = win_s ? 2'b10 : 2'b01;
                    rx_d   = sel_rx_s;
                    tx_d   = sel_tx_s;
                    miso_d = win_s ? req1_wdata : req0_wdata;
                    freq_d = win_s ? req1_freq : req0_freq;
                    if (sel_rx_s || sel_tx_s) begin
                        state_d    = ST_LAUNCH;
                        rx_start_d = sel_rx_s;
                        tx_start_d = sel_tx_s;
                        cs_bar_d   = 1'b1;
                    end else begin
                        // Nothing to transfer: flag it from HOLDOFF on the next cycle
                        state_d = ST_HOLDOFF;
                        null_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d   = ST_WAIT;
                tmo_cnt_d = {TMO_W{1'b0}};
            end
            ST_WAIT: begin
                if (complete_s) begin
                    done_d    = gnt_q;
                    gnt_d     = 2'b00;
                    last_d    = idx_q;
                    rdata_d   = rx_q ? spi_mosi_data : rdata_q;
                    gap_cnt_d = {GAP_W{1'b0}};
                    state_d   = ST_HOLDOFF;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    done_d    = gnt_q;
                    err_d     = gnt_q;
                    gnt_d     = 2'b00;
                    last_d    = idx_q;
                    gap_cnt_d = {GAP_W{1'b0}};
                    state_d   = ST_HOLDOFF;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (null_q) begin
                    done_d    = gnt_q;
                    err_d     = gnt_q;
                    gnt_d     = 2'b00;
                    last_d    = idx_q;
                    null_d    = 1'b0;
                    gap_cnt_d = {GAP_W{1'b0}};
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; pointer resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            idx_q      <= 1'b0;
            rx_q       <= 1'b0;
            tx_q       <= 1'b0;
            null_q     <= 1'b0;
            tmo_cnt_q  <= {TMO_W{1'b0}};
            gap_cnt_q  <= {GAP_W{1'b0}};
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rdata_q    <= {DATA_WIDTH{1'b0}};
            busy_q     <= 1'b0;
            rx_start_q <= 1'b0;
            tx_start_q <= 1'b0;
            miso_q     <= {DATA_WIDTH{1'b0}};
            freq_q     <= 2'b00;
            cs_bar_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            null_q     <= null_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            rx_start_q <= rx_start_d;
            tx_start_q <= tx_start_d;
            miso_q     <= miso_d;
            freq_q     <= freq_d;
            cs_bar_q   <= cs_bar_d;
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign busy          = busy_q;
    assign spi_rx_start  = rx_start_q;
    assign spi_tx_start  = tx_start_q;
    assign spi_miso_data = miso_q;
    assign spi_freq      = freq_q;
    assign spi_cs_bar    = cs_bar_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed self-checking bench for spi_xfer_arbiter with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spi_xfer_arbiter;

    localparam int DW   = 16;
    localparam int TMO  = 4096;
    localparam int GAP  = 64;

    logic          clk;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    req_rx;
    logic [1:0]    req_tx;
    logic [DW-1:0] req0_wdata;
    logic [DW-1:0] req1_wdata;
    logic [1:0]    req0_freq;
    logic [1:0]    req1_freq;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic [1:0]    err;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          spi_rx_start;
    logic          spi_tx_start;
    logic [DW-1:0] spi_miso_data;
    logic [1:0]    spi_freq;
    logic          spi_cs_bar;
    logic          spi_rx_valid;
    logic          spi_tx_done;
    logic [DW-1:0] spi_mosi_data;

    int checks;
    int errors;
    int cyc;
    int launch0;
    int launch1;
    int n;
    int bad;

    spi_xfer_arbiter #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_rx       (req_rx),
        .req_tx       (req_tx),
        .req0_wdata   (req0_wdata),
        .req1_wdata   (req1_wdata),
        .req0_freq    (req0_freq),
        .req1_freq    (req1_freq),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .busy         (busy),
        .spi_rx_start (spi_rx_start),
        .spi_tx_start (spi_tx_start),
        .spi_miso_data(spi_miso_data),
        .spi_freq     (spi_freq),
        .spi_cs_bar   (spi_cs_bar),
        .spi_rx_valid (spi_rx_valid),
        .spi_tx_done  (spi_tx_done),
        .spi_mosi_data(spi_mosi_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until busy drops, bounded
    task automatic count_to_idle(output int cnt);
        cnt = 0;
        while (busy !== 1'b0 && cnt < 1000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},   32'(gnt),           32'h0);
        chk({tag, "_done"},  32'(done),          32'h0);
        chk({tag, "_err"},   32'(err),           32'h0);
        chk({tag, "_rdata"}, 32'(rdata),         32'h0);
        chk({tag, "_busy"},  32'(busy),          32'h0);
        chk({tag, "_rxs"},   32'(spi_rx_start),  32'h0);
        chk({tag, "_txs"},   32'(spi_tx_start),  32'h0);
        chk({tag, "_miso"},  32'(spi_miso_data), 32'h0);
        chk({tag, "_freq"},  32'(spi_freq),      32'h0);
        chk({tag, "_csb"},   32'(spi_cs_bar),    32'h0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        reset = 1'b1; req = 2'b00; req_rx = 2'b00; req_tx = 2'b00;
        req0_wdata = 16'h0000; req1_wdata = 16'h0000;
        req0_freq = 2'b00; req1_freq = 2'b00;
        spi_rx_valid = 1'b0; spi_tx_done = 1'b0; spi_mosi_data = 16'h0000;

        tick(); tick();
        chk_reset_vals("rst");

        // Round robin with both requesting from reset: 0 first, then 1
        reset = 1'b0;
        req = 2'b11; req_rx = 2'b11; req_tx = 2'b00;
        req0_wdata = 16'h1111; req1_wdata = 16'h2222;
        req0_freq = 2'b01; req1_freq = 2'b11;
        spi_mosi_data = 16'h0BEE;
        tick();
        launch0 = cyc;
        chk("rr_gnt0",  32'(gnt),           32'h1);
        chk("rr_rxs0",  32'(spi_rx_start),  32'h1);
        chk("rr_txs0",  32'(spi_tx_start),  32'h0);
        chk("rr_miso0", 32'(spi_miso_data), 32'h1111);
        chk("rr_freq0", 32'(spi_freq),      32'h1);
        chk("rr_busy0", 32'(busy),          32'h1);
        tick();
        spi_tx_done = 1'b1;
        tick();
        spi_tx_done = 1'b0;
        chk("rr_done0",  32'(done),  32'h1);
        chk("rr_err0",   32'(err),   32'h0);
        chk("rr_rdata0", 32'(rdata), 32'h0BEE);
        spi_mosi_data = 16'h0C0D;
        n = 0;
        while (gnt === 2'b00 && n < 500) begin
            tick();
            n++;
        end
        launch1 = cyc;
        chk("rr_gnt1",  32'(gnt),               32'h2);
        chk("rr_miso1", 32'(spi_miso_data),     32'h2222);
        chk("rr_freq1", 32'(spi_freq),          32'h3);
        chk("rr_gap",   32'(launch1 - launch0), 32'(GAP + 3));
        tick();
        spi_tx_done = 1'b1;
        tick();
        spi_tx_done = 1'b0;
        req = 2'b00;
        chk("rr_done1",  32'(done),  32'h2);
        chk("rr_rdata1", 32'(rdata), 32'h0C0D);
        count_to_idle(n);
        chk("rr_holdoff", 32'(n), 32'(GAP));

        // Basic rx+tx transfer on requester 0
        req = 2'b01; req_rx = 2'b01; req_tx = 2'b01;
        req0_wdata = 16'hA5C3; req0_freq = 2'b10;
        tick();
        chk("b_gnt",  32'(gnt),           32'h1);
        chk("b_rxs",  32'(spi_rx_start),  32'h1);
        chk("b_txs",  32'(spi_tx_start),  32'h1);
        chk("b_csb",  32'(spi_cs_bar),    32'h1);
        chk("b_freq", 32'(spi_freq),      32'h2);
        chk("b_miso", 32'(spi_miso_data), 32'hA5C3);
        req = 2'b00;
        tick();
        chk("b_rxs_off", 32'(spi_rx_start), 32'h0);
        chk("b_txs_off", 32'(spi_tx_start), 32'h0);
        chk("b_csb_off", 32'(spi_cs_bar),   32'h0);
        chk("b_gnt_hold", 32'(gnt),         32'h1);
        spi_mosi_data = 16'h1234; spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        chk("b_done",  32'(done),  32'h1);
        chk("b_err",   32'(err),   32'h0);
        chk("b_gnt0",  32'(gnt),   32'h0);
        chk("b_rdata", 32'(rdata), 32'h1234);
        // Re-request on the done cycle: only served after holdoff
        req = 2'b01;
        tick();
        n = 1;
        chk("b_done_pulse", 32'(done),     32'h0);
        chk("b_freq_hold",  32'(spi_freq), 32'h2);
        while (gnt === 2'b00 && n < 500) begin
            tick();
            n++;
        end
        chk("rearb_lat", 32'(n),   32'(GAP + 1));
        chk("rearb_gnt", 32'(gnt), 32'h1);

        // Completion on the very cycle the timeout expires
        tick();
        req = 2'b00;
        bad = 0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            if (done !== 2'b00) bad++;
        end
        spi_rx_valid = 1'b1; spi_mosi_data = 16'hBEEF;
        tick();
        spi_rx_valid = 1'b0;
        chk("tie_early", 32'(bad),   32'h0);
        chk("tie_done",  32'(done),  32'h1);
        chk("tie_err",   32'(err),   32'h0);
        chk("tie_rdata", 32'(rdata), 32'hBEEF);
        count_to_idle(n);
        chk("tie_idle", 32'(busy), 32'h0);

        // Timeout on requester 1, rdata untouched
        req = 2'b10; req_rx = 2'b10; req_tx = 2'b00;
        req1_wdata = 16'h3C3C; req1_freq = 2'b01;
        tick();
        chk("to_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        spi_mosi_data = 16'hDEAD;
        tick();
        bad = 0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            if (done !== 2'b00) bad++;
        end
        chk("to_early", 32'(bad), 32'h0);
        tick();
        chk("to_done",  32'(done),  32'h2);
        chk("to_err",   32'(err),   32'h2);
        chk("to_gnt0",  32'(gnt),   32'h0);
        chk("to_rdata", 32'(rdata), 32'hBEEF);
        tick();
        chk("to_err_pulse", 32'(err), 32'h0);
        count_to_idle(n);
        chk("to_idle", 32'(busy), 32'h0);

        // Winner with neither rx nor tx: no start, done+err one cycle after grant
        req = 2'b01; req_rx = 2'b00; req_tx = 2'b00;
        tick();
        chk("nul_gnt", 32'(gnt),          32'h1);
        chk("nul_rxs", 32'(spi_rx_start), 32'h0);
        chk("nul_txs", 32'(spi_tx_start), 32'h0);
        chk("nul_csb", 32'(spi_cs_bar),   32'h0);
        req = 2'b00;
        tick();
        chk("nul_done", 32'(done), 32'h1);
        chk("nul_err",  32'(err),  32'h1);
        chk("nul_gnt0", 32'(gnt),  32'h0);
        tick();
        chk("nul_done_pulse", 32'(done), 32'h0);
        count_to_idle(n);
        chk("nul_holdoff", 32'(n), 32'(GAP - 1));

        // Reset during WAIT aborts at once; then a fresh request is served
        req = 2'b10; req_rx = 2'b10; req_tx = 2'b10;
        req1_wdata = 16'h5A5A; req1_freq = 2'b01;
        tick();
        chk("ra_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1 chk_reset_vals("ra");
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        chk("ra_no_done", 32'(done), 32'h0);
        reset = 1'b0;
        req = 2'b10; req_rx = 2'b10; req_tx = 2'b00;
        tick();
        chk("ra_gnt_new", 32'(gnt),          32'h2);
        chk("ra_rxs_new", 32'(spi_rx_start), 32'h1);
        chk("ra_csb_new", 32'(spi_cs_bar),   32'h1);
        req = 2'b00;
        tick();
        spi_rx_valid = 1'b1; spi_mosi_data = 16'h7777;
        tick();
        spi_rx_valid = 1'b0;
        chk("ra_done_new",  32'(done),  32'h2);
        chk("ra_rdata_new", 32'(rdata), 32'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_arbiter.md
SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, SPI frame width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum WAIT duration in clk cycles.
REQ-003 SHALL have parameter GAP_CYCLES, default 64, holdoff between frames in clk cycles (at least 50).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port req, input, 2, per-requester transfer request; bit i belongs to requester i.
REQ-007 SHALL have ports req_rx and req_tx, input, 2 each, per-requester receive and transmit enables.
REQ-008 SHALL have ports req0_wdata and req1_wdata, input, DATA_WIDTH each, transmit words.
REQ-009 SHALL have ports req0_freq and req1_freq, input, 2 each, freq_control code per requester.
REQ-010 SHALL have port gnt, output, 2, one-hot grant, held for the whole transaction.
REQ-011 SHALL have port done, output, 2, one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port err, output, 2, one-cycle timeout/illegal flag, coincident with done.
REQ-013 SHALL have port rdata, output, DATA_WIDTH, the last received word.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have ports spi_rx_start and spi_tx_start, output, 1 each, start pulses to the SPI core.
REQ-016 SHALL have port spi_miso_data, output, DATA_WIDTH, the word to transmit.
REQ-017 SHALL have port spi_freq, output, 2, clock select to the SPI core.
REQ-018 SHALL have port spi_cs_bar, output, 1, chip-select level to the SPI core.
REQ-019 SHALL have ports spi_rx_valid and spi_tx_done, input, 1 each, completion flags from the SPI core.
REQ-020 SHALL have port spi_mosi_data, input, DATA_WIDTH, received word from the SPI core.

Function
REQ-021 SHALL implement the states IDLE, LAUNCH, WAIT and HOLDOFF; all outputs SHALL be registered.
REQ-022 IDLE: a request is valid when req[i] is high. The block SHALL pick a winner, latch its wdata, freq, rx and tx, set gnt, and move to LAUNCH on the next edge.
REQ-023 Arbitration SHALL be round-robin on a last-served pointer. With both requests valid, the requester not served last wins. Out of reset, requester 0 wins a tie.
REQ-024 LAUNCH lasts exactly 1 cycle: spi_rx_start = latched rx and spi_tx_start = latched tx, with spi_cs_bar = 1. Next state is WAIT.
REQ-025 spi_cs_bar SHALL be 0 in all states other than LAUNCH.
REQ-026 spi_miso_data and spi_freq SHALL stay stable from LAUNCH until HOLDOFF ends.
REQ-027 A winner with req_rx = req_tx = 0 SHALL skip LAUNCH and WAIT. It SHALL get done and err on the cycle after the grant, then go to HOLDOFF.
REQ-028 WAIT, normal completion: the first cycle with spi_rx_valid or spi_tx_done high ends the transaction. If rx was latched, rdata <= spi_mosi_data. done[i] pulses, gnt clears, err = 0, next state is HOLDOFF.
REQ-029 WAIT, timeout: a counter clears on entry and increments each cycle. At TIMEOUT_CYCLES-1 with no completion, done[i] and err[i] pulse, rdata is held, gnt clears, next state is HOLDOFF.
REQ-030 If completion and timeout occur in the same cycle, completion SHALL win and err = 0.
REQ-031 HOLDOFF SHALL count GAP_CYCLES cycles, then go to IDLE; requests are ignored during HOLDOFF.
REQ-032 The last-served pointer SHALL update when done pulses.
REQ-033 Requesters SHALL hold req until done; deasserting req after the grant SHALL NOT abort the transaction.
REQ-034 Requests re-asserted on the cycle done pulses SHALL be arbitrated only after HOLDOFF.
REQ-035 Latency, normal launch: req high at IDLE cycle N gives gnt and start at cycle N+1.
REQ-036 Latency, completion: spi_rx_valid at cycle M gives done at cycle M+1.

Reset
REQ-037 While reset is high, the block SHALL be in IDLE with the pointer at 1, so requester 0 wins the first tie.
REQ-038 Reset values SHALL be: gnt, done and err = 0; rdata = 0; busy = 0; spi_rx_start and spi_tx_start = 0; spi_miso_data = 0; spi_freq = 2'b00; spi_cs_bar = 0.
REQ-039 Reset asserted mid-transaction SHALL abort immediately with no done pulse.
REQ-040 After reset deasserts, arbitration SHALL resume on the next edge.

Verification
REQ-041 req = 01, rx = tx = 1, wdata 16'hA5C3, freq 10, core returns spi_mosi_data 16'h1234 with spi_rx_valid -> one start pulse each, spi_freq = 10, rdata = 16'h1234, one done[0] pulse, err = 0.
REQ-042 req = 11 held for two transactions -> first grant to requester 0, second to requester 1, with at least GAP_CYCLES cycles between the two LAUNCH states.
REQ-043 req = 10, no completion flag ever -> done[1] and err[1] pulse exactly TIMEOUT_CYCLES cycles after WAIT entry; rdata unchanged.
REQ-044 req = 01 with rx = tx = 0 -> no start pulse; done[0] and err[0] one cycle after the grant.
REQ-045 Reset pulsed during WAIT -> all outputs at reset values within the same cycle; no done; after release, a new req = 10 is granted normally.
REQ-046 Completion flag on the same cycle the timeout counter expires -> done with err = 0 and rdata captured.
